// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared integer-pipeline types: register index and data word widths, the
// architectural register count, and the writeback-stage entry carried from the
// arbiter to the register-file write port.
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam int REGADDR  = 5;   // significant register-index bits
    localparam int NREG     = 32;  // architectural integer registers
    localparam int BITWIDTH = 32;  // data and register-file address width

    typedef logic [REGADDR-1:0]  reg_idx_t;
    typedef logic [BITWIDTH-1:0] word_t;

    // One registered register-file write.
    typedef struct packed {
        logic     valid;
        reg_idx_t idx;
        word_t    data;
    } wb_entry_t;

    // The register-file address bus is a full word; the index is zero-extended.
    function automatic word_t reg_to_word(input reg_idx_t idx);
        return word_t'(idx);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Generic N-way round-robin arbiter. The search starts at an internal pointer;
// after a grant to requester g the pointer moves to (g+1) mod N, so the winner
// becomes lowest priority. With no requests the pointer holds.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-high reset (pointer returns to 0)
//   req_i          request vector
//   grant_o        one-hot grant (only ever set on a requesting bit)
//   grant_valid_o  some requester was granted this cycle
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output logic         grant_valid_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Scan N positions starting at the pointer; the first requester found wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment, otherwise the untaken paths infer latches.
        grant_o       = '0;
        grant_valid_o = 1'b0;
        ptr_d         = ptr_q;
        idx           = '0;
        for (int off = 0; off < N; off++) begin
            idx = PTR_W'((int'(ptr_q) + off) % N);
            if (!grant_valid_o && req_i[idx]) begin
                grant_o[idx]  = 1'b1;
                grant_valid_o = 1'b1;
                ptr_d         = PTR_W'((int'(idx) + 1) % N);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the integer register file's single write port among NREQ functional
// units with round-robin arbitration, registering one write per cycle, and
// keeps a busy-bit scoreboard of destinations with an outstanding writeback so
// issue logic can stall on RAW (chk_busy) and WAW (issue_conflict) hazards.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid/ready per-requester result handshake (one ready per cycle max)
//   req_reg/data    per-requester destination register and result value
//   issue_valid/reg instruction issued with a destination register
//   issue_conflict  issue_reg is busy: issue must stall
//   chk_reg         source registers on the read ports
//   chk_busy        per read port: source not yet written, stall
//   rf_wr, rf_wd    register-file write enables (identical)
//   rf_write_reg    write address, zero-extended register index
//   rf_write_data   write data
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
    import rv_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int NRWORD = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ-1:0][REGADDR-1:0]     req_reg,
    input  logic [NREQ-1:0][BITWIDTH-1:0]    req_data,
    input  logic                             issue_valid,
    input  logic [REGADDR-1:0]               issue_reg,
    output logic                             issue_conflict,
    input  logic [NRWORD-1:0][REGADDR-1:0]   chk_reg,
    output logic [NRWORD-1:0]                chk_busy,
    output logic                             rf_wr,
    output logic                             rf_wd,
    output logic [BITWIDTH-1:0]              rf_write_reg,
    output logic [BITWIDTH-1:0]              rf_write_data
);

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NREQ-1:0] grant;
    logic            grant_valid;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_valid),
        .grant_o      (grant),
        .grant_valid_o(grant_valid)
    );

    // The output stage never back-pressures, so a grant is an acceptance.
    // During reset nothing is accepted: in-flight requesters are dropped.
    assign req_ready = rst ? '0 : grant;

    // One-hot select of the granted requester's destination and data.
    reg_idx_t sel_reg;
    word_t    sel_data;

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_reg  = req_reg[i];
                sel_data = req_data[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: drives the register-file write port for one cycle
    // ------------------------------------------------------------------
    wb_entry_t out_q;
    wb_entry_t out_d;

    // A grant targeting x0 is consumed but produces no write. Index and data
    // only reload on a real write; they are don't-care while valid is low.
    always_comb begin
        out_d       = out_q;
        out_d.valid = 1'b0;
        if (grant_valid && (sel_reg != '0)) begin
            out_d.valid = 1'b1;
            out_d.idx   = sel_reg;
            out_d.data  = sel_data;
        end
    end

    // The asynchronous reset drops a pending write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign rf_wr         = out_q.valid;
    assign rf_wd         = out_q.valid;
    assign rf_write_reg  = reg_to_word(out_q.idx);
    assign rf_write_data = out_q.data;

    // ------------------------------------------------------------------
    // Busy-bit scoreboard
    // ------------------------------------------------------------------
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // The clear is applied first so an issue to the register being written in
    // the same cycle leaves it busy (the new producer is still outstanding).
    always_comb begin
        busy_d = busy_q;
        if (out_q.valid) begin
            busy_d[out_q.idx] = 1'b0;
        end
        if (issue_valid && (issue_reg != '0)) begin
            busy_d[issue_reg] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: the scoreboard is reset even though it is array-like: stale busy
    // bits after reset would stall issue forever, unlike a data RAM whose
    // contents are simply overwritten before use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Hazard comparators
    // ------------------------------------------------------------------
    // The register file bypasses its write port to the read ports, so a
    // source being written this cycle is already available.
    always_comb begin
        chk_busy = '0;
        for (int i = 0; i < NRWORD; i++) begin
            chk_busy[i] = busy_q[chk_reg[i]] &&
                          !(out_q.valid && (out_q.idx == chk_reg[i]));
        end
    end

    assign issue_conflict = busy_q[issue_reg] && (issue_reg != '0);

    // ------------------------------------------------------------------
    // Interface rules
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NREQ; i++) begin : g_req_hold
        a_req_hold: assert property (@(posedge clk) disable iff (rst)
            (req_valid[i] && !req_ready[i]) |=>
                (req_valid[i] && $stable(req_reg[i]) && $stable(req_data[i])));
    end

    a_issue_legal: assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && issue_conflict));

endmodule
